// File: rtl/gpa_fhdo_spi_multi.sv
// GPA-FHDO gradient DAC serialiser: one update of up to NUM_CH words becomes an optional
// sync-register frame plus one 24-bit SPI frame per enabled channel, with SDI readback.
module gpa_fhdo_spi_multi #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CSN_GAP = 2,
  parameter int SYNC_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic                     valid_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o,
  output logic                     fhd_clk_o,
  output logic                     fhd_sdo_o,
  output logic                     fhd_csn_o,
  input  logic                     fhd_sdi_i,
  output logic [23:0]              rdback_o,
  output logic                     rdback_valid_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CSN_GAP - 1);
  localparam logic [3:0]       SYNC_ADDR = 4'h2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                     state_r;
  logic [NUM_CH*DATA_W-1:0]   data_r;
  logic [NUM_CH-1:0]          rem_r;
  logic                       sync_pend_r;
  logic [22:0]                shreg_r;
  logic [23:0]                cap_r;
  logic [DIV_W-1:0]           div_cnt_r;
  logic [4:0]                 bit_cnt_r;
  logic [GAP_W-1:0]           gap_cnt_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       ovf_r;
  logic                       sclk_r;
  logic                       sdo_r;
  logic                       csn_r;
  logic [23:0]                rdback_r;
  logic                       rdback_valid_r;

  logic [NUM_CH-1:0]          low_s;
  logic [2:0]                 sel_s;
  logic [DATA_W-1:0]          word_s;
  logic [23:0]                frame_s;
  logic [23:0]                cap_next_s;
  logic                       sample_s;
  logic                       accept_s;
  logic                       half_end_s;
  logic                       last_bit_s;

  // Left-justify a channel word into the 16-bit payload, zero-filling the LSBs.
  function automatic logic [15:0] justify(input logic [DATA_W-1:0] w);
    logic [15:0] p;
    p = 16'h0000;
    p[15 -: DATA_W] = w;
    return p;
  endfunction

  function automatic logic [23:0] make_frame(input logic [3:0] addr, input logic [15:0] payload);
    return {4'h0, addr, payload};
  endfunction

  // Isolate the lowest pending channel: ascending index order falls out of the two's-complement trick.
  assign low_s      = rem_r & (~rem_r + NUM_CH'(1));
  assign accept_s   = (SYNC_EN != 0) || (|ch_mask_i);
  assign half_end_s = (div_cnt_r == DIV_LAST);
  assign last_bit_s = (bit_cnt_r == 5'd23);
  assign sample_s   = (state_r == SHIFT) && !sclk_r && (div_cnt_r == {DIV_W{1'b0}});
  assign cap_next_s = sample_s ? {cap_r[22:0], fhd_sdi_i} : cap_r;

  // Channel index and word selected by the one-hot lowest-pending mask.
  always_comb begin
    sel_s  = 3'd0;
    word_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s  = sel_s | (low_s[i] ? 3'(i) : 3'd0);
      word_s = word_s | (low_s[i] ? data_r[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
  end

  // Next frame word: the sync frame always precedes the channel frames.
  always_comb begin
    frame_s = 24'h000000;
    if (sync_pend_r) begin
      frame_s = make_frame(SYNC_ADDR, 16'h0000);
    end else begin
      frame_s = make_frame({1'b1, sel_s}, justify(word_s));
    end
  end

  // Transfer sequencer, SPI bit engine and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      data_r         <= {(NUM_CH*DATA_W){1'b0}};
      rem_r          <= {NUM_CH{1'b0}};
      sync_pend_r    <= 1'b0;
      shreg_r        <= 23'h000000;
      cap_r          <= 24'h000000;
      div_cnt_r      <= {DIV_W{1'b0}};
      bit_cnt_r      <= 5'd0;
      gap_cnt_r      <= {GAP_W{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      ovf_r          <= 1'b0;
      sclk_r         <= 1'b1;
      sdo_r          <= 1'b0;
      csn_r          <= 1'b1;
      rdback_r       <= 24'h000000;
      rdback_valid_r <= 1'b0;
    end else begin
      done_r         <= 1'b0;
      rdback_valid_r <= 1'b0;
      ovf_r          <= valid_i && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (valid_i && accept_s) begin
            data_r      <= data_i;
            rem_r       <= ch_mask_i;
            sync_pend_r <= (SYNC_EN != 0);
            busy_r      <= 1'b1;
            state_r     <= LOAD;
          end
        end
        LOAD: begin
          shreg_r   <= frame_s[22:0];
          sdo_r     <= frame_s[23];
          csn_r     <= 1'b0;
          sclk_r    <= 1'b1;
          div_cnt_r <= {DIV_W{1'b0}};
          bit_cnt_r <= 5'd0;
          if (sync_pend_r) begin
            sync_pend_r <= 1'b0;
          end else begin
            rem_r <= rem_r & ~low_s;
          end
          state_r <= SHIFT;
        end
        SHIFT: begin
          cap_r <= cap_next_s;
          if (half_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (sclk_r) begin
              sclk_r <= 1'b0;
            end else if (last_bit_s) begin
              sclk_r         <= 1'b1;
              csn_r          <= 1'b1;
              sdo_r          <= 1'b0;
              rdback_r       <= cap_next_s;
              rdback_valid_r <= 1'b1;
              gap_cnt_r      <= {GAP_W{1'b0}};
              state_r        <= GAP;
            end else begin
              sclk_r    <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 5'd1;
              sdo_r     <= shreg_r[22];
              shreg_r   <= {shreg_r[21:0], 1'b0};
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            if (sync_pend_r || (|rem_r)) begin
              state_r <= LOAD;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          sclk_r  <= 1'b1;
          csn_r   <= 1'b1;
          sdo_r   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign ovf_o          = ovf_r;
  assign fhd_clk_o      = sclk_r;
  assign fhd_sdo_o      = sdo_r;
  assign fhd_csn_o      = csn_r;
  assign rdback_o       = rdback_r;
  assign rdback_valid_o = rdback_valid_r;

endmodule
